// File: rtl/mips_mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback cycles and drives the datapath selects and strobes.
module mips_mc_control_fsm #(
    parameter int OPW  = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  op,
    input  logic            mem_ready,
    output logic            iord,
    output logic            mem_write,
    output logic            mem_read,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            pc_write,
    output logic            branch,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // fetch_en / memwr_en are the ungated forms of the mem_ready-qualified strobes
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       pc_write;
        logic       fetch_en;
        logic       memwr_en;
        logic       in_decode;
    } ctrl_t;

    function automatic logic op_legal(input logic [OPW-1:0] o);
        logic ok;
        case (o)
            OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.fetch_en  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.in_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwr_en = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    // next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_RTYP)         state_d = S_EXECUTE;
                else if (op == OP_BEQ)          state_d = S_BRANCH;
                else if (op == OP_ADDI)         state_d = S_ADDIEX;
                else if (op == OP_J)            state_d = S_JUMP;
                else                            state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (op == OP_LW) state_d = S_MEMRD;
                else             state_d = S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
                else           state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
                else           state_d = S_MEMWR;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // state register; control register is loaded with the decode of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
        end
    end

    assign iord       = ctrl_q.iord;
    assign mem_read   = ctrl_q.mem_read;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign branch     = ctrl_q.branch;
    // FETCH is the reset state, so its gated strobes are also held off by rst_n
    assign ir_write   = ctrl_q.fetch_en & mem_ready & rst_n;
    assign pc_write   = ctrl_q.pc_write | (ctrl_q.fetch_en & mem_ready & rst_n);
    assign mem_write  = ctrl_q.memwr_en & mem_ready;
    assign illegal_op = ctrl_q.in_decode & ~op_legal(op);
    assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Self-checking bench for mips_mc_control_fsm: per-instruction expected cycle traces,
// directed table, randomized traffic and hand-written reset corner cases.
module tb_mips_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, mem_write, mem_read, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_write, branch, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_mc_control_fsm #(.OPW(6), .ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .mem_read(mem_read), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_write(pc_write), .branch(branch),
        .illegal_op(illegal_op), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       iord, mem_write, mem_read, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       pc_write, branch, illegal_op;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        exp_t       e;
    } vec_t;

    typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_ILL} kind_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic kind_t kind_of(input logic [5:0] o);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a = {state, iord, mem_write, mem_read, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_src, pc_write, branch, illegal_op};
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    function automatic void push(input logic [5:0] o, input logic r, input exp_t e);
        vec_t v;
        v.op = o; v.rdy = r; v.e = e;
        tbl.push_back(v);
    endfunction

    // Builds the expected cycle-by-cycle trace of one instruction. With scr set,
    // op and mem_ready are randomized wherever the controller must ignore them.
    function automatic void gen_instr(input logic [5:0] o, input int fw, input int mw, input bit scr);
        exp_t  e;
        kind_t k = kind_of(o);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            push(scr ? 6'($urandom) : o, 1'b0, e);
        end
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(scr ? 6'($urandom) : o, 1'b1, e);
        e = '0; e.st = 4'd1; e.alu_src_b = 2'b11; e.illegal_op = (k == K_ILL);
        push(o, scr ? 1'($urandom) : 1'b1, e);
        if (k == K_LW || k == K_SW) begin
            e = '0; e.st = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            push(o, scr ? 1'($urandom) : 1'b1, e);
        end
        case (k)
            K_LW: begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.st = 4'd3; e.iord = 1'b1; e.mem_read = 1'b1;
                    push(scr ? 6'($urandom) : o, (i == mw), e);
                end
                e = '0; e.st = 4'd4; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
            end
            K_SW: begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.st = 4'd5; e.iord = 1'b1; e.mem_write = (i == mw);
                    push(scr ? 6'($urandom) : o, (i == mw), e);
                end
            end
            K_R: begin
                e = '0; e.st = 4'd6; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
                e = '0; e.st = 4'd7; e.reg_dst = 1'b1; e.reg_write = 1'b1;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
            end
            K_BEQ: begin
                e = '0; e.st = 4'd8; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1'b1;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
            end
            K_ADDI: begin
                e = '0; e.st = 4'd9; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
                e = '0; e.st = 4'd10; e.reg_write = 1'b1;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
            end
            K_J: begin
                e = '0; e.st = 4'd11; e.pc_src = 2'b10; e.pc_write = 1'b1;
                push(scr ? 6'($urandom) : o, scr ? 1'($urandom) : 1'b1, e);
            end
            default: ;
        endcase
    endfunction

    // Called at a falling edge: drive inputs, check settled outputs, advance one cycle.
    task automatic apply(input vec_t v);
        exp_t a;
        op = v.op; mem_ready = v.rdy;
        #1;
        a = sample();
        check("state", 32'(a.st), 32'(v.e.st));
        check("ctrl", 32'(a), 32'(v.e));
        @(negedge clk);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        int   cnt;
        exp_t e;
        vec_t v;
        rst_n = 1'b0; op = 6'b100011; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'({ir_write, pc_write, mem_write, reg_write, branch, illegal_op}), 32'd0);
        check("rst_alu_src_b", 32'(alu_src_b), 32'(2'b01));
        @(negedge clk);
        rst_n = 1'b1;

        // directed instruction sequence
        gen_instr(6'b100011, 2, 0, 1'b0);
        gen_instr(6'b101011, 0, 3, 1'b0);
        gen_instr(6'b000000, 0, 0, 1'b0);
        gen_instr(6'b000100, 0, 0, 1'b0);
        gen_instr(6'b000010, 0, 0, 1'b0);
        gen_instr(6'b111111, 0, 0, 1'b0);
        gen_instr(6'b001000, 1, 0, 1'b0);
        gen_instr(6'b100011, 0, 2, 1'b0);
        run_table();

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [5:0] o;
            if ($urandom_range(0, 7) >= 6) o = 6'($urandom);
            else                           o = ops[$urandom_range(0, 5)];
            gen_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        end
        run_table();

        // LW up to MEMWB, then asynchronous reset between clock edges
        op = 6'b100011; mem_ready = 1'b1; cnt = 0;
        #1;
        while (state != 4'd4 && cnt < 20) begin
            @(negedge clk); #1; cnt++;
        end
        check("lw_cycles_to_memwb", 32'(cnt), 32'd4);
        check("memwb_reg_write", 32'(reg_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_strobes", 32'({reg_write, mem_write, ir_write, pc_write}), 32'd0);
        @(negedge clk);
        check("rst_hold_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        v.op = 6'b000000; v.rdy = 1'b1; v.e = e;
        apply(v);
        #1;
        check("post_rst_decode", 32'(state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_mc_control_fsm.md
Name: mips_mc_control_fsm

Overview:
- Main control state machine for the multi-cycle MIPS datapath.
- Sequences every instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the selects of the datapath operand multiplexers, including the 2-bit ALU-B source select of the 4-input mux, and the register, memory and PC write strobes.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- OPW, 6, opcode field width.
- ST_W, 4, state encoding width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  6  instr[31:26] from the instruction register.
- mem_ready  input  1  memory access completes this cycle.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write register select: 0=rt, 1=rd.
- mem_to_reg  output  1  writeback data select: 0=ALUOut, 1=MDR.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A source: 0=PC, 1=A.
- alu_src_b  output  2  ALU B source: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2.
- alu_op  output  2  ALU decode class: 00=add, 01=sub, 10=funct.
- pc_src  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target.
- pc_write  output  1  unconditional PC load.
- branch  output  1  conditional PC load; the datapath ANDs it with zero.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  ST_W  current state, for debug.

Behaviour:
- Architecture: Moore state register with asynchronous clear. Outputs are decoded from the state. Strobes marked "gated" are also ANDed with mem_ready.
- Reset: state=FETCH (0) while rst_n=0. Every strobe is 0 during reset: mem_write, ir_write, reg_write, pc_write, branch, illegal_op. Selects take their FETCH values.
- States and transitions:
  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write are gated. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by op:
    - 100011 (LW) or 101011 (SW) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (BEQ) -> BRANCH.
    - 001000 (ADDI) -> ADDIEX.
    - 000010 (J) -> JUMP.
    - any other op -> FETCH, with illegal_op=1 in this DECODE cycle.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if op=LW, otherwise MEMWR.
  - MEMRD(3): iord=1, mem_read=1. Holds while mem_ready=0; goes to MEMWB on mem_ready=1.
  - MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
  - MEMWR(5): iord=1. mem_write is gated, i.e. asserted for exactly the mem_ready cycle. Holds while mem_ready=0; goes to FETCH on mem_ready=1.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - ALUWB(7): reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 -> FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB(10): reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
  - JUMP(11): pc_src=10, pc_write=1 -> FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH and drive all strobes 0.
- Defaults: any output not listed for a state is 0.
- op sampling: op is sampled only in DECODE and MEMADR. The instruction register is stable there because ir_write=0 outside FETCH.
- Latency in cycles, with no memory wait:
  - LW: 5.
  - SW, R-type, ADDI: 4.
  - BEQ, J: 3.
  - Each cycle of mem_ready=0 in a memory state adds one cycle.
- Reset mid-operation: the state returns to FETCH immediately and asynchronously. Strobes drop in the same instant and no partial write is issued.
- mem_ready outside memory states: ignored.

Test Plan:
- Reset and fetch: hold rst_n=0, then release with mem_ready=0 for 2 cycles, then 1.
  - Required: state=0 for 3 cycles.
  - Required: ir_write=pc_write=1 only in the third cycle, with alu_src_b=01.
  - Required: next state=1.
- LW, op=100011, mem_ready always 1.
  - Required state sequence: 0,1,2,3,4,0.
  - Required: alu_src_b=10 in state 2; iord=1 in state 3; reg_write=1 with mem_to_reg=1 in state 4.
- SW with 3 wait cycles: op=101011, mem_ready low for 3 cycles in MEMWR.
  - Required: state 5 for 4 cycles.
  - Required: mem_write=1 only in the last of those cycles.
- R-type then BEQ.
  - R-type (op=000000) required: states 6 then 7; alu_op=10, reg_dst=1.
  - BEQ (op=000100) required: state 8 with branch=1, pc_src=01, alu_op=01, alu_src_b=00.
- J and illegal opcode.
  - J (op=000010) required: state 11 with pc_write=1, pc_src=10.
  - Illegal (op=111111) required: illegal_op=1 for one cycle in DECODE, then FETCH, with no reg_write or mem_write issued.
- Async reset mid-LW: drop rst_n during MEMWB, between clock edges.
  - Required: reg_write falls immediately and state=0 without waiting for a clock.
